// File: rtl/sram_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sram_stage_sequencer
// Brief    : Runs up to NUM_CLIENTS SRAM processing stages in ascending index
//            order under a latched enable mask. Each stage gets a start/finish
//            handshake and owns the single SRAM port while it runs. When no
//            stage owns the port, the default reader (VGA) drives it.
// Options  : define SEQ_WATCHDOG_EN to build the per-stage watchdog
//            (TIMEOUT_CYCLES limit, sticky Error flag).
// Revision : 1.0 - initial release
// ============================================================================
module sram_stage_sequencer #(
  parameter int NUM_CLIENTS    = 3,
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_W      = 26,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          Go,
  input  logic                          Abort,
  input  logic [NUM_CLIENTS-1:0]        Stage_mask,
  output logic [NUM_CLIENTS-1:0]        Client_start,
  input  logic [NUM_CLIENTS-1:0]        Client_finish,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] Client_address,
  input  logic [NUM_CLIENTS*DATA_W-1:0] Client_write_data,
  input  logic [NUM_CLIENTS-1:0]        Client_we_n,
  input  logic [ADDR_W-1:0]             Default_address,
  output logic [ADDR_W-1:0]             SRAM_address,
  output logic [DATA_W-1:0]             SRAM_write_data,
  output logic                          SRAM_we_n,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Error,
  output logic [2:0]                    Active_stage
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_RUN    = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [NUM_CLIENTS-1:0] r_mask;
  logic [NUM_CLIENTS-1:0] r_owner;
  // Cursor can reach NUM_CLIENTS (one past the last stage), hence 4 bits.
  logic [3:0]             r_cursor;

  logic                   w_sel_found;
  logic [2:0]             w_sel_idx;
  logic [NUM_CLIENTS-1:0] w_sel_onehot;
  logic                   w_active_finish;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [TIMEOUT_W-1:0] C_WDOG_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] r_wdog;
`else
  assign Error = 1'b0;
`endif

  // Lowest enabled stage at or above the cursor; descending scan so the lowest hit wins.
  always_comb begin
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    w_sel_onehot = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (r_mask[i] && (i >= int'(r_cursor))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = 3'(i);
      end
    end
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_sel_found && (w_sel_idx == 3'(i))) begin
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  // Only the owning client's finish counts; masking with the owner ignores all others.
  assign w_active_finish = |(Client_finish & r_owner);

  assign Busy = (r_state != S_IDLE);

  // SRAM port mux: owner client when one is set, otherwise the idle (VGA) reader with writes off.
  always_comb begin
    SRAM_address    = Default_address;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (r_owner[i]) begin
        SRAM_address    = Client_address[i*ADDR_W +: ADDR_W];
        SRAM_write_data = Client_write_data[i*DATA_W +: DATA_W];
        SRAM_we_n       = Client_we_n[i];
      end
    end
  end

  // Sequencer FSM: select -> run -> gap per stage, abort and watchdog return to idle without Done.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_owner      <= '0;
      r_cursor     <= '0;
      Client_start <= '0;
      Done         <= 1'b0;
      Active_stage <= '0;
`ifdef SEQ_WATCHDOG_EN
      r_wdog       <= '0;
      Error        <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Go) begin
            r_mask   <= Stage_mask;
            r_cursor <= '0;
`ifdef SEQ_WATCHDOG_EN
            Error    <= 1'b0;
`endif
            // An empty mask completes immediately without leaving idle.
            if (Stage_mask == '0) begin
              Done <= 1'b1;
            end else begin
              r_state <= S_SELECT;
            end
          end
        end

        S_SELECT: begin
          if (Abort) begin
            r_state <= S_IDLE;
          end else if (w_sel_found) begin
            Client_start <= w_sel_onehot;
            r_owner      <= w_sel_onehot;
            Active_stage <= w_sel_idx;
`ifdef SEQ_WATCHDOG_EN
            r_wdog       <= '0;
`endif
            r_state      <= S_RUN;
          end else begin
            Done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_RUN: begin
          if (Abort) begin
            Client_start <= '0;
            r_owner      <= '0;
            r_state      <= S_IDLE;
          end else if (w_active_finish) begin
            Client_start <= '0;
            r_owner      <= '0;
            r_cursor     <= {1'b0, Active_stage} + 4'd1;
            r_state      <= S_GAP;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (r_wdog == C_WDOG_LIMIT) begin
            Error        <= 1'b1;
            Client_start <= '0;
            r_owner      <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end

        S_GAP: begin
          // Owner is already cleared here, so the port shows we_n=1 across the handover.
          if (Abort) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_SELECT;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_stage_sequencer
// Brief    : Directed scoreboard bench for sram_stage_sequencer. Stimulus
//            pushes expected start/done/error events with their cycle numbers;
//            a monitor pops and compares whenever the DUT shows one, and also
//            checks the SRAM mux every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_stage_sequencer;

  localparam int NC = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam logic [AW-1:0] C_DEF_ADDR = 18'h3ABCD;

  logic            clk;
  logic            resetn;
  logic            go;
  logic            abort;
  logic [NC-1:0]   stage_mask;
  logic [NC-1:0]   client_start;
  logic [NC-1:0]   client_finish;
  logic [NC-1:0]   resp_fin;
  logic [NC-1:0]   ext_fin;
  logic [NC*AW-1:0] client_address;
  logic [NC*DW-1:0] client_write_data;
  logic [NC-1:0]   client_we_n;
  logic [AW-1:0]   sram_address;
  logic [DW-1:0]   sram_write_data;
  logic            sram_we_n;
  logic            busy;
  logic            done;
  logic            error;
  logic [2:0]      active_stage;

  assign client_finish = resp_fin | ext_fin;

  sram_stage_sequencer #(
    .NUM_CLIENTS   (NC),
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_W     (26),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .Clock            (clk),
    .Resetn           (resetn),
    .Go               (go),
    .Abort            (abort),
    .Stage_mask       (stage_mask),
    .Client_start     (client_start),
    .Client_finish    (client_finish),
    .Client_address   (client_address),
    .Client_write_data(client_write_data),
    .Client_we_n      (client_we_n),
    .Default_address  (C_DEF_ADDR),
    .SRAM_address     (sram_address),
    .SRAM_write_data  (sram_write_data),
    .SRAM_we_n        (sram_we_n),
    .Busy             (busy),
    .Done             (done),
    .Error            (error),
    .Active_stage     (active_stage)
  );

  typedef struct {
    int kind;   // 0 = start, 1 = done, 2 = error rise
    int idx;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  dly[NC];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [AW-1:0] exp_addr(input int i);
    return AW'(32'h01000 + i);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int i);
    return DW'(32'hA5A0 + i);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int idx, input int c);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic sb_event(input int kind, input int idx);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d idx %0d at cycle %0d, expected none", kind, idx, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.idx != idx || e.cyc != cyc) begin
        fails++;
        $display("FAIL event: got kind %0d idx %0d cycle %0d expected kind %0d idx %0d cycle %0d",
                 kind, idx, cyc, e.kind, e.idx, e.cyc);
      end
      if (kind == 0) check("active_stage_on_start", int'(active_stage), idx);
    end
  endtask

  // Monitor: event scoreboard plus per-cycle SRAM mux and handshake checks.
  initial begin
    logic [NC-1:0] prev_start;
    logic          prev_err;
    int            owner;
    prev_start = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_start = '0;
        prev_err   = 1'b0;
        continue;
      end
      for (int i = 0; i < NC; i++)
        if (client_start[i] && !prev_start[i]) sb_event(0, i);
      if (done) begin
        sb_event(1, 0);
        check("busy_low_with_done", int'(busy), 0);
      end
      if (error && !prev_err) sb_event(2, 0);
      if ($countones(client_start) > 1) check("start_onehot", int'(client_start), 0);
      if (client_start == '0) begin
        tests++;
        if (sram_we_n !== 1'b1 || sram_address !== C_DEF_ADDR || sram_write_data !== '0) begin
          fails++;
          $display("FAIL idle_mux: got addr %h data %h we_n %b expected addr %h data 0 we_n 1",
                   sram_address, sram_write_data, sram_we_n, C_DEF_ADDR);
        end
      end else begin
        owner = 0;
        for (int i = 0; i < NC; i++) if (client_start[i]) owner = i;
        tests++;
        if (sram_address !== exp_addr(owner) || sram_write_data !== exp_data(owner) || sram_we_n !== 1'b0) begin
          fails++;
          $display("FAIL client_mux: got addr %h data %h we_n %b expected addr %h data %h we_n 0",
                   sram_address, sram_write_data, sram_we_n, exp_addr(owner), exp_data(owner));
        end
      end
      prev_start = client_start;
      prev_err   = error;
    end
  end

  // Client responder: finish pulse dly[i] cycles after start rises (negative = never).
  initial begin
    logic [NC-1:0] rprev;
    int            due[NC];
    bit            armed[NC];
    rprev    = '0;
    resp_fin = '0;
    for (int i = 0; i < NC; i++) begin
      due[i]   = 0;
      armed[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      resp_fin = '0;
      for (int i = 0; i < NC; i++) begin
        if (client_start[i] && !rprev[i] && dly[i] >= 0) begin
          armed[i] = 1'b1;
          due[i]   = cyc + dly[i];
        end
        if (!client_start[i]) armed[i] = 1'b0;
        if (armed[i] && due[i] == cyc) begin
          resp_fin[i] = 1'b1;
          armed[i]    = 1'b0;
        end
      end
      rprev = client_start;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_go(input logic [NC-1:0] m);
    stage_mask = m;
    go         = 1'b1;
    @(negedge clk);
    go         = 1'b0;
  endtask

  task automatic drain(input string name);
    check(name, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation reached cycle %0d without finishing", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int n;
    resetn     = 1'b0;
    go         = 1'b0;
    abort      = 1'b0;
    stage_mask = '0;
    ext_fin    = '0;
    client_we_n = '0;
    for (int i = 0; i < NC; i++) begin
      dly[i] = 10;
      client_address[i*AW +: AW]    = exp_addr(i);
      client_write_data[i*DW +: DW] = exp_data(i);
    end
    repeat (3) @(negedge clk);
    check("rst_start", int'(client_start), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active_stage", int'(active_stage), 0);
    check("rst_sram_addr", int'(sram_address), int'(C_DEF_ADDR));
    check("rst_sram_we_n", int'(sram_we_n), 1);
    check("rst_sram_data", int'(sram_write_data), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Full mask, 10-cycle clients: stages 0,1,2 then one Done.
    n = cyc;
    push(0, 0, n + 2); push(0, 1, n + 15); push(0, 2, n + 28); push(1, 0, n + 41);
    pulse_go(3'b111);
    check("busy_after_go", int'(busy), 1);
    wait_until(n + 45);
    check("busy_after_done", int'(busy), 0);
    drain("drain_mask111");

    // Sparse mask skips stage 1.
    n = cyc;
    push(0, 0, n + 2); push(0, 2, n + 15); push(1, 0, n + 28);
    pulse_go(3'b101);
    wait_until(n + 32);
    check("last_active_stage", int'(active_stage), 2);
    drain("drain_mask101");

    // Empty mask: Done on the next cycle, never busy.
    n = cyc;
    push(1, 0, n + 1);
    pulse_go(3'b000);
    check("mask0_busy", int'(busy), 0);
    check("mask0_start", int'(client_start), 0);
    wait_until(n + 5);
    drain("drain_mask000");

    // Abort five cycles into stage 1, then a normal run.
    n = cyc;
    push(0, 0, n + 2); push(0, 1, n + 15);
    pulse_go(3'b111);
    wait_until(n + 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_start", int'(client_start), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_addr", int'(sram_address), int'(C_DEF_ADDR));
    wait_until(n + 35);
    drain("drain_abort");
    n = cyc;
    push(0, 1, n + 2); push(1, 0, n + 15);
    pulse_go(3'b010);
    wait_until(n + 19);
    drain("drain_after_abort");

    // Foreign finish and Go while busy are ignored.
    n = cyc;
    push(0, 0, n + 2); push(1, 0, n + 15);
    pulse_go(3'b001);
    wait_until(n + 5);
    ext_fin = 3'b100;
    @(negedge clk);
    ext_fin = '0;
    check("foreign_finish_start", int'(client_start), 1);
    check("foreign_finish_addr", int'(sram_address), int'(exp_addr(0)));
    wait_until(n + 7);
    pulse_go(3'b111);
    check("go_while_busy_busy", int'(busy), 1);
    wait_until(n + 22);
    drain("drain_ignore");

    // Finish in the same cycle start rises is honoured.
    dly[0] = 0;
    n = cyc;
    push(0, 0, n + 2); push(1, 0, n + 5);
    pulse_go(3'b001);
    wait_until(n + 9);
    drain("drain_same_cycle_finish");
    dly[0] = 10;

`ifdef SEQ_WATCHDOG_EN
    // Watchdog: client 0 never finishes.
    dly[0] = -1;
    n = cyc;
    push(0, 0, n + 2); push(2, 0, n + 102);
    pulse_go(3'b001);
    wait_until(n + 105);
    check("wdog_error", int'(error), 1);
    check("wdog_busy", int'(busy), 0);
    check("wdog_start", int'(client_start), 0);
    drain("drain_watchdog");
    dly[0] = 10;
    n = cyc;
    push(1, 0, n + 1);
    pulse_go(3'b000);
    check("go_clears_error", int'(error), 0);
    wait_until(n + 4);
    drain("drain_error_clear");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
